// File: rtl/overture_pkg.sv
// Shared types for the Overture run controller: FSM states and halt-reason codes.
package overture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } run_state_t;

    typedef enum logic [2:0] {
        HR_NONE  = 3'd0,
        HR_STOP  = 3'd1,
        HR_BP    = 3'd2,
        HR_LIMIT = 3'd3,
        HR_STEP  = 3'd4
    } halt_reason_t;

endpackage

// File: rtl/overture_run_ctrl.sv
// Execution controller for the Overture CPU: turns start/step/stop pulses into a gated
// run level, halting on a PC breakpoint or a per-launch cycle budget.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | out of reset, nothing launched yet
// RUN     | continuous execution until stop, breakpoint or cycle limit
// STEP    | one run cycle (unless aborted by stop), then HALTED
// HALTED  | stopped; halt_reason says why, start/step relaunch
module overture_run_ctrl
    import overture_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int CYCLE_LIMIT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic             bp_en,
    input  logic [7:0]       bp_addr,
    input  logic [7:0]       cpu_pc,
    output logic             run,
    output logic             busy,
    output logic             halted,
    output logic [2:0]       halt_reason,
    output logic [CNT_W-1:0] cycle_count
);

    run_state_t       state, state_nxt;
    halt_reason_t     reason_q, reason_nxt;
    logic [CNT_W-1:0] count_q;
    logic             skip_bp, skip_bp_nxt;
    logic             launch;
    logic             bp_hit;
    logic             limit_hit;

    // skip_bp lets a resume execute the instruction that caused the breakpoint halt.
    assign bp_hit    = bp_en && (cpu_pc == bp_addr) && !skip_bp;
    assign limit_hit = (CYCLE_LIMIT != 0) && (count_q == CNT_W'(CYCLE_LIMIT));

    always_comb begin
        state_nxt   = state;
        reason_nxt  = reason_q;
        skip_bp_nxt = skip_bp;
        launch      = 1'b0;
        run         = 1'b0;
        case (state)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_nxt   = ST_RUN;
                    launch      = 1'b1;
                    skip_bp_nxt = (state == ST_HALTED);
                end else if (step) begin
                    state_nxt   = ST_STEP;
                    launch      = 1'b1;
                    skip_bp_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt  = ST_HALTED;
                    reason_nxt = HR_STOP;
                end else if (bp_hit) begin
                    state_nxt  = ST_HALTED;
                    reason_nxt = HR_BP;
                end else if (limit_hit) begin
                    state_nxt  = ST_HALTED;
                    reason_nxt = HR_LIMIT;
                end else begin
                    run = 1'b1;
                end
            end
            ST_STEP: begin
                state_nxt  = ST_HALTED;
                reason_nxt = stop ? HR_STOP : HR_STEP;
                run        = !stop;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (launch) begin
            reason_nxt = HR_NONE;
        end
        if (run) begin
            skip_bp_nxt = 1'b0;
        end
        // Reset kills run in the same cycle so the CPU never advances under reset.
        if (reset) begin
            run = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            reason_q <= HR_NONE;
            count_q  <= '0;
            skip_bp  <= 1'b0;
        end else begin
            state    <= state_nxt;
            reason_q <= reason_nxt;
            skip_bp  <= skip_bp_nxt;
            if (launch) begin
                count_q <= '0;
            end else if (run && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign busy        = (state == ST_RUN) || (state == ST_STEP);
    assign halted      = (state == ST_HALTED);
    assign halt_reason = reason_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_overture_run_ctrl.sv
// Bench for overture_run_ctrl: stub CPU plus a per-cycle reference model, a vector
// table, hand-written corner sequences and randomized command traffic.
module tb_overture_run_ctrl;

    localparam int LIMIT  = 10;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_HALT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        stop = 1'b0;
    logic        bp_en = 1'b0;
    logic [7:0]  bp_addr = 8'd0;
    logic [7:0]  cpu_pc;
    logic        run, busy, halted;
    logic [2:0]  halt_reason;
    logic [15:0] cycle_count;
    logic        run2, busy2, halted2;
    logic [2:0]  halt_reason2;
    logic [3:0]  cycle_count2;

    int vec_cnt = 0;
    int err_cnt = 0;
    int run_seen = 0;

    int m_mode = M_IDLE;
    int m_reason = 0;
    int m_count = 0;
    int m_pc = 0;
    bit m_skip = 1'b0;

    int last_run, last_busy, last_halted, last_reason, last_count, last_pc;

    typedef struct {
        bit rst, st, sp, so;
        int e_run, e_busy, e_halt, e_reason, e_count, e_pc;
    } vec_t;
    vec_t tbl[$];

    overture_run_ctrl #(.CNT_W(16), .CYCLE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .start(start), .step(step), .stop(stop),
        .bp_en(bp_en), .bp_addr(bp_addr), .cpu_pc(cpu_pc),
        .run(run), .busy(busy), .halted(halted),
        .halt_reason(halt_reason), .cycle_count(cycle_count)
    );

    // Narrow counter with the limit disabled, used only to see saturation.
    overture_run_ctrl #(.CNT_W(4), .CYCLE_LIMIT(0)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .step(step), .stop(stop),
        .bp_en(1'b0), .bp_addr(8'd0), .cpu_pc(8'd0),
        .run(run2), .busy(busy2), .halted(halted2),
        .halt_reason(halt_reason2), .cycle_count(cycle_count2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cpu_pc <= 8'd0;
        else if (run) cpu_pc <= cpu_pc + 8'd1;
    end

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: check against the model mid-cycle, advance the model, then clear pulses.
    task automatic tick();
        bit er, bp_hit, lim_hit;
        @(negedge clk);
        bp_hit  = bp_en && (m_pc == int'(bp_addr)) && !m_skip;
        lim_hit = (LIMIT != 0) && (m_count == LIMIT);
        er = 1'b0;
        if (!reset) begin
            if (m_mode == M_RUN) er = !stop && !bp_hit && !lim_hit;
            else if (m_mode == M_STEP) er = !stop;
        end
        last_run = int'(run); last_busy = int'(busy); last_halted = int'(halted);
        last_reason = int'(halt_reason); last_count = int'(cycle_count); last_pc = int'(cpu_pc);
        check("m_run", last_run, int'(er));
        check("m_busy", last_busy, int'(m_mode == M_RUN || m_mode == M_STEP));
        check("m_halted", last_halted, int'(m_mode == M_HALT));
        check("m_reason", last_reason, m_reason);
        check("m_count", last_count, m_count);
        check("m_pc", last_pc, m_pc);
        if (run) run_seen++;
        if (reset) begin
            m_mode = M_IDLE; m_reason = 0; m_count = 0; m_skip = 1'b0; m_pc = 0;
        end else begin
            if (er) begin
                if (m_count < 65535) m_count++;
                m_pc = (m_pc + 1) % 256;
                m_skip = 1'b0;
            end
            case (m_mode)
                M_IDLE, M_HALT: begin
                    if (start) begin
                        m_skip = (m_mode == M_HALT);
                        m_mode = M_RUN; m_count = 0; m_reason = 0;
                    end else if (step) begin
                        m_mode = M_STEP; m_count = 0; m_reason = 0;
                    end
                end
                M_RUN: if (!er) begin
                    m_mode = M_HALT;
                    m_reason = stop ? 1 : (bp_hit ? 2 : 3);
                end
                default: begin
                    m_mode = M_HALT;
                    m_reason = stop ? 1 : 4;
                end
            endcase
        end
        @(posedge clk);
        #1;
        start = 1'b0; step = 1'b0; stop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(bit rst, bit st, bit sp, bit so,
                                int r, int b, int h, int rs, int c, int p);
        vec_t v;
        v.rst = rst; v.st = st; v.sp = sp; v.so = so;
        v.e_run = r; v.e_busy = b; v.e_halt = h; v.e_reason = rs; v.e_count = c; v.e_pc = p;
        return v;
    endfunction

    initial begin
        int r0;
        @(posedge clk);
        #1;
        do_reset();

        // Steps with a breakpoint that must be ignored, a stop-aborted step,
        // start+step from HALTED, stop in RUN.
        bp_en = 1'b1; bp_addr = 8'd1;
        //             rst st sp so  run busy halt rsn cnt pc
        tbl.push_back(mk(1, 0, 0, 0,  0,  0,   0,   0,  0,  0));
        tbl.push_back(mk(0, 0, 1, 0,  0,  0,   0,   0,  0,  0));
        tbl.push_back(mk(0, 0, 0, 0,  1,  1,   0,   0,  0,  0));
        tbl.push_back(mk(0, 0, 0, 0,  0,  0,   1,   4,  1,  1));
        tbl.push_back(mk(0, 0, 0, 0,  0,  0,   1,   4,  1,  1));
        tbl.push_back(mk(0, 0, 1, 0,  0,  0,   1,   4,  1,  1));
        tbl.push_back(mk(0, 0, 0, 0,  1,  1,   0,   0,  0,  1));
        tbl.push_back(mk(0, 0, 0, 0,  0,  0,   1,   4,  1,  2));
        tbl.push_back(mk(0, 0, 1, 0,  0,  0,   1,   4,  1,  2));
        tbl.push_back(mk(0, 0, 0, 1,  0,  1,   0,   0,  0,  2));
        tbl.push_back(mk(0, 0, 0, 0,  0,  0,   1,   1,  0,  2));
        tbl.push_back(mk(0, 1, 1, 0,  0,  0,   1,   1,  0,  2));
        tbl.push_back(mk(0, 0, 0, 1,  0,  1,   0,   0,  0,  2));
        tbl.push_back(mk(0, 0, 0, 0,  0,  0,   1,   1,  0,  2));
        tbl.push_back(mk(0, 1, 0, 0,  0,  0,   1,   1,  0,  2));
        tbl.push_back(mk(0, 0, 0, 0,  1,  1,   0,   0,  0,  2));
        tbl.push_back(mk(0, 0, 0, 0,  1,  1,   0,   0,  1,  3));
        tbl.push_back(mk(0, 0, 0, 1,  0,  1,   0,   0,  2,  4));
        tbl.push_back(mk(0, 0, 0, 0,  0,  0,   1,   1,  2,  4));
        foreach (tbl[i]) begin
            reset = tbl[i].rst; start = tbl[i].st; step = tbl[i].sp; stop = tbl[i].so;
            tick();
            check($sformatf("tbl%0d_run", i), last_run, tbl[i].e_run);
            check($sformatf("tbl%0d_busy", i), last_busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_halted", i), last_halted, tbl[i].e_halt);
            check($sformatf("tbl%0d_reason", i), last_reason, tbl[i].e_reason);
            check($sformatf("tbl%0d_count", i), last_count, tbl[i].e_count);
            check($sformatf("tbl%0d_pc", i), last_pc, tbl[i].e_pc);
        end
        reset = 1'b0;

        // Breakpoint halt at pc 5.
        do_reset();
        bp_en = 1'b1; bp_addr = 8'd5;
        r0 = run_seen;
        start = 1'b1; tick();
        for (int i = 0; i < 40 && !halted; i++) tick();
        check("bp_runs", run_seen - r0, 5);
        check("bp_count", int'(cycle_count), 5);
        check("bp_halted", int'(halted), 1);
        check("bp_reason", int'(halt_reason), 2);
        check("bp_pc", int'(cpu_pc), 5);

        // Resume past the breakpoint, stop at pc 9.
        r0 = run_seen;
        start = 1'b1; tick();
        for (int i = 0; i < 40 && cpu_pc != 8'd9 && !halted; i++) tick();
        check("resume_pc9", int'(cpu_pc), 9);
        check("resume_no_rehalt", int'(halted), 0);
        stop = 1'b1; tick();
        tick();
        check("resume_reason", int'(halt_reason), 1);
        check("resume_count", int'(cycle_count), 4);
        check("resume_runs", run_seen - r0, 4);

        // Cycle limit.
        do_reset();
        bp_en = 1'b0;
        r0 = run_seen;
        start = 1'b1; tick();
        for (int i = 0; i < 40 && !halted; i++) tick();
        check("lim_runs", run_seen - r0, 10);
        check("lim_reason", int'(halt_reason), 3);
        check("lim_count", int'(cycle_count), 10);
        check("lim_halted", int'(halted), 1);

        // Three single steps four cycles apart; breakpoint at 1 ignored.
        do_reset();
        bp_en = 1'b1; bp_addr = 8'd1;
        for (int k = 0; k < 3; k++) begin
            r0 = run_seen;
            step = 1'b1; tick();
            tick(); tick(); tick();
            check("step_pc", int'(cpu_pc), k + 1);
            check("step_runs", run_seen - r0, 1);
            check("step_reason", int'(halt_reason), 4);
        end

        // start+step together in IDLE: start wins.
        do_reset();
        bp_en = 1'b0;
        start = 1'b1; step = 1'b1; tick();
        tick(); tick();
        check("both_busy", int'(busy), 1);
        check("both_count", int'(cycle_count), 2);

        // stop coinciding with a breakpoint hit.
        do_reset();
        bp_en = 1'b1; bp_addr = 8'd3;
        start = 1'b1; tick();
        for (int i = 0; i < 20 && cpu_pc != 8'd3 && !halted; i++) tick();
        stop = 1'b1; tick();
        tick();
        check("stopbp_reason", int'(halt_reason), 1);
        check("stopbp_pc", int'(cpu_pc), 3);

        // start while running is ignored.
        do_reset();
        bp_en = 1'b0;
        start = 1'b1; tick();
        tick(); tick(); tick();
        start = 1'b1; tick();
        check("restart_count", int'(cycle_count), 4);
        check("restart_busy", int'(busy), 1);

        // Reset in cycle 3 of a run.
        do_reset();
        start = 1'b1; tick();
        tick(); tick();
        reset = 1'b1; tick();
        check("rstmid_run", last_run, 0);
        reset = 1'b0;
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_halted", int'(halted), 0);
        check("rstmid_reason", int'(halt_reason), 0);
        check("rstmid_count", int'(cycle_count), 0);

        // Saturation of the narrow counter.
        do_reset();
        start = 1'b1; tick();
        for (int i = 0; i < 20; i++) tick();
        check("sat_count", int'(cycle_count2), 15);
        check("sat_run", int'(run2), 1);

        // Randomized commands against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 9) == 0);
            step  = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 15) == 0) bp_en = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) bp_addr = 8'(int'(cpu_pc) + $urandom_range(0, 8));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/overture_run_ctrl.md
# overture_run_ctrl

Execution controller that sits directly upstream of the Overture CPU program wrappers and drives their `run` input. It turns start/step/stop command pulses into a gated `run` level. It halts the CPU on a PC breakpoint or after a per-launch cycle budget, and reports why execution stopped. The benches and top-levels of the `pgm_overture_*` programs use it to run programs to completion or single-step them.

## Interface
Parameters:
- `CNT_W`, 16: width of the executed-cycle counter.
- `CYCLE_LIMIT`, 1000: maximum run cycles per launch. A value of 0 disables the limit.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse. Launches or resumes continuous execution.
- `step` in 1: one-cycle pulse. Executes exactly one CPU cycle.
- `stop` in 1: one-cycle pulse. Halts continuous execution.
- `bp_en` in 1: enables the breakpoint compare.
- `bp_addr` in 8: breakpoint PC.
- `cpu_pc` in 8: current CPU `pc`, which is a registered CPU output.
- `run` out 1: drives the CPU `run` input. The CPU advances exactly one instruction on each cycle in which `run` is 1.
- `busy` out 1: high in the RUN and STEP states.
- `halted` out 1: high in the HALTED state.
- `halt_reason` out 3: reason for the last halt. NONE=0, STOP=1, BP=2, LIMIT=3, STEP=4.
- `cycle_count` out CNT_W: number of run cycles since the last launch.

## Operation
States:
- IDLE
  - `start` goes to RUN. `step` goes to STEP. If both are asserted, `start` wins.
  - `stop` is ignored.
- RUN
  - Run cycles repeat until a halt condition fires.
  - Halt conditions are evaluated every cycle, in priority order:
    1. `stop` gives HALTED with reason STOP.
    2. A breakpoint hit gives HALTED with reason BP. A hit is `bp_en && cpu_pc==bp_addr && !skip_bp`.
    3. A limit hit gives HALTED with reason LIMIT. A hit is `CYCLE_LIMIT!=0 && cycle_count==CYCLE_LIMIT`.
- STEP
  - Exactly one run cycle, with breakpoint and limit ignored, then HALTED with reason STEP.
  - `stop` in STEP aborts the step before it executes: no run cycle, reason STOP.
- HALTED
  - `start` goes to RUN. `step` goes to STEP. Otherwise the state holds.

Launch behaviour (`start` or `step` accepted from IDLE or HALTED):
- `cycle_count` clears to 0 and `halt_reason` clears to NONE.
- A `start` accepted from HALTED also sets `skip_bp`, so a resume from a breakpoint executes the breakpoint instruction instead of re-halting.
- `skip_bp` clears after the first run cycle.
- `start` or `step` while busy is ignored.

Run output and counting:
- `run` is combinational: `(state==RUN && no halt condition this cycle) || (state==STEP && !stop)`, gated by `!reset`.
- Because of this gating, the instruction at `bp_addr` does not execute on a breakpoint halt, and no extra cycle leaks on a stop or limit halt.
- `cycle_count` increments on every cycle with `run`=1 and saturates at all-ones.

Reset values:
- state IDLE, `run` 0, `busy` 0, `halted` 0, `halt_reason` NONE, `cycle_count` 0, `skip_bp` 0.
- Reset asserted mid-run forces `run`=0 in the same cycle and takes the state to IDLE at the next edge.

## Timing
- Command-to-run latency is 1 cycle. A `start` sampled at edge N gives `run`=1 in cycle N+1.
- The halt decision is made in the same cycle as the condition: `run`=0 that cycle, and HALTED is visible at the next edge.
- A step produces exactly one `run`=1 cycle. `halted` rises 1 cycle after that run cycle.
- There is no combinational path from any input to `cpu_pc`. The `cpu_pc`→`run` path is the only combinational path through the CPU.

## Structure
- `overture_pkg` holds `run_state_t` (IDLE, RUN, STEP, HALTED) and `halt_reason_t` (the encodings above).
- The block is a single module with no sub-module. The logic is an FSM plus one counter and one flag.

## Test plan
The bench uses a stub CPU whose `pc` starts at 0 and increments on each `run` cycle.
- Breakpoint halt: reset, `bp_en`=1, `bp_addr`=5, pulse `start` → exactly 5 `run` cycles, `cycle_count`=5, `halted`=1, `halt_reason`=2, `cpu_pc`=5.
- Resume past breakpoint: from the breakpoint halt, pulse `start` → `run` stays 1 past pc 5, no re-halt at 5. Pulse `stop` at pc 9 → `halt_reason`=1, `cycle_count`=4.
- Cycle limit: `CYCLE_LIMIT`=10, `bp_en`=0, pulse `start` → 10 `run` cycles, `halt_reason`=3, `cycle_count`=10.
- Single step: three `step` pulses 4 cycles apart → `pc` goes 0→1→2→3, each step gives one `run` cycle, `halt_reason`=4, and `bp_addr`=1 with `bp_en`=1 is ignored.
- Simultaneous events, first case: `start`+`step` together in IDLE → RUN.
- Simultaneous events, second case: `stop` in the same cycle as a breakpoint hit → `halt_reason`=1.
- Simultaneous events, third case: `start` while RUN → ignored, `cycle_count` not cleared.
- Reset mid-run: `reset` at cycle 3 of a run → `run`=0 that cycle, IDLE next, all outputs at their reset values.
